// File: rtl/sccb_pkg.sv
// sccb_pkg
//   Shared definitions for the SCCB configuration sequencer: ROM entry
//   layout, opcode encoding, FSM state encoding and small helpers that
//   slice a ROM entry into its fields.
package sccb_pkg;

  // ROM entry layout: {op[1:0], reg[7:0], val[7:0]}
  localparam int ENTRY_W = 18;
  localparam int OP_W    = 2;
  localparam int REG_W   = 8;
  localparam int VAL_W   = 8;
  localparam int VAL_LSB = 0;
  localparam int REG_LSB = VAL_LSB + VAL_W;
  localparam int OP_LSB  = REG_LSB + REG_W;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_VERIFY = 2'd1,
    OP_DELAY  = 2'd2,
    OP_END    = 2'd3
  } opcode_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WRITE,
    ST_WAIT_W,
    ST_READ,
    ST_WAIT_R,
    ST_RETRY,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } state_t;

  function automatic opcode_t entry_op(input logic [ENTRY_W-1:0] e);
    return opcode_t'(e[OP_LSB +: OP_W]);
  endfunction

  function automatic logic [REG_W-1:0] entry_reg(input logic [ENTRY_W-1:0] e);
    return e[REG_LSB +: REG_W];
  endfunction

  function automatic logic [VAL_W-1:0] entry_val(input logic [ENTRY_W-1:0] e);
    return e[VAL_LSB +: VAL_W];
  endfunction

endpackage

// File: rtl/sccb_delay_timer.sv
// sccb_delay_timer
//   Loadable down-counter measuring a delay of ticks_in x DELAY_UNIT cycles.
//   A prescaler divides clk into ticks; a tick counter counts ticks down.
//   Ports:
//     clk, reset   clock, asynchronous active-low reset
//     load         capture ticks_in and restart the prescaler
//     ticks_in     delay length in ticks (must be nonzero to ever expire)
//     run          count while high
//     expired      high during the final cycle of the delay
module sccb_delay_timer #(
  parameter int DELAY_UNIT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] ticks_in,
  input  logic       run,
  output logic       expired
);

  localparam int PRE_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DELAY_UNIT - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       tick_cnt;

  // Prescaler wraps every DELAY_UNIT cycles and takes one tick off the
  // tick counter at each wrap; the counters stop once the ticks run out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else if (load) begin
      pre_cnt  <= PRE_MAX;
      tick_cnt <= ticks_in;
    end else if (run && (tick_cnt != 8'd0)) begin
      if (pre_cnt == '0) begin
        pre_cnt  <= PRE_MAX;
        tick_cnt <= tick_cnt - 8'd1;
      end else begin
        pre_cnt <= pre_cnt - PRE_W'(1);
      end
    end
  end

  // Asserted on the last cycle so the caller leaves on the very next edge,
  // making the delay exactly ticks_in x DELAY_UNIT cycles long.
  assign expired = run && (tick_cnt == 8'd1) && (pre_cnt == '0);

endmodule

// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer
//   Walks a synchronous configuration ROM and drives an external I2C/SCCB
//   master one transaction at a time: writes, write-with-readback, timed
//   delays and early END, with a bounded retry of failing entries.
//   Ports:
//     clk, reset            clock, asynchronous active-low reset
//     start                 begin a run (only looked at while idle)
//     rom_addr / rom_entry  ROM address out, entry back one cycle later
//     i2c_start/read/dev_id/reg/wdata   command to the master
//     i2c_done/ack_ok/rdata             completion from the master
//     busy, done, error, err_index      run status
module sccb_config_sequencer
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int         NUM_ENTRIES = 26,
  parameter int         ADDR_W      = 6,
  parameter int         DELAY_UNIT  = 50000,
  parameter int         MAX_RETRIES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [ENTRY_W-1:0] rom_entry,
  output logic               i2c_start,
  output logic               i2c_read,
  output logic [7:0]         i2c_dev_id,
  output logic [7:0]         i2c_reg,
  output logic [7:0]         i2c_wdata,
  input  logic               i2c_done,
  input  logic               i2c_ack_ok,
  input  logic [7:0]         i2c_rdata,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  err_index
);

  // Entry index is one bit wider than the ROM address so a table that fills
  // the whole address space ends by count instead of wrapping back to 0.
  localparam int IDX_W   = ADDR_W + 1;
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [IDX_W-1:0]   NUM_ENTRIES_IDX = IDX_W'(NUM_ENTRIES);
  localparam logic [RETRY_W-1:0] RETRY_MAX       = RETRY_W'(MAX_RETRIES);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   entry_idx;
  logic [RETRY_W-1:0] retry_cnt;
  logic               verify_q;
  logic               past_end;
  logic               retry_left;
  logic               timer_expired;
  logic               timer_load;
  logic               timer_run;

  assign past_end   = (entry_idx >= NUM_ENTRIES_IDX);
  assign retry_left = (retry_cnt < RETRY_MAX);

  // The delay length is taken straight from the ROM entry while it is being
  // decoded, so the count starts on the first DELAY cycle.
  assign timer_load = (state == ST_DECODE);
  assign timer_run  = (state == ST_DELAY);

  sccb_delay_timer #(
    .DELAY_UNIT(DELAY_UNIT)
  ) u_delay_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .ticks_in (entry_val(rom_entry)),
    .run      (timer_run),
    .expired  (timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the outputs that follow directly from the state.
  always_comb begin
    state_next = state;
    i2c_start  = 1'b0;
    i2c_read   = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    i2c_dev_id = DEVICE_ID;
    rom_addr   = entry_idx[ADDR_W] ? {ADDR_W{1'b1}} : entry_idx[ADDR_W-1:0];

    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        state_next = past_end ? ST_DONE : ST_DECODE;
      end
      ST_DECODE: begin
        case (entry_op(rom_entry))
          OP_WRITE, OP_VERIFY: state_next = ST_WRITE;
          // A zero-length delay spends no cycles in DELAY at all.
          OP_DELAY: state_next = (entry_val(rom_entry) == 8'd0) ? ST_NEXT : ST_DELAY;
          default:  state_next = ST_DONE;
        endcase
      end
      ST_WRITE: begin
        i2c_start  = 1'b1;
        state_next = ST_WAIT_W;
      end
      ST_WAIT_W: begin
        if (i2c_done) begin
          if (!i2c_ack_ok)   state_next = ST_RETRY;
          else if (verify_q) state_next = ST_READ;
          else               state_next = ST_NEXT;
        end
      end
      ST_READ: begin
        i2c_start  = 1'b1;
        i2c_read   = 1'b1;
        state_next = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (i2c_done) begin
          if (!i2c_ack_ok || (i2c_rdata != i2c_wdata)) state_next = ST_RETRY;
          else                                         state_next = ST_NEXT;
        end
      end
      ST_RETRY: begin
        state_next = retry_left ? ST_WRITE : ST_FAIL;
      end
      ST_DELAY: begin
        if (timer_expired) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        state_next = ST_FETCH;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_FAIL: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: entry index, retry count, latched command fields and status.
  // The command fields are captured once per entry so retries reissue the
  // exact same register/value even though the ROM output is not re-read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_idx <= '0;
      retry_cnt <= '0;
      verify_q  <= 1'b0;
      i2c_reg   <= 8'd0;
      i2c_wdata <= 8'd0;
      error     <= 1'b0;
      err_index <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          entry_idx <= '0;
          if (start) begin
            error     <= 1'b0;
            err_index <= '0;
            retry_cnt <= '0;
          end
        end
        ST_DECODE: begin
          i2c_reg   <= entry_reg(rom_entry);
          i2c_wdata <= entry_val(rom_entry);
          verify_q  <= (entry_op(rom_entry) == OP_VERIFY);
        end
        ST_RETRY: begin
          if (retry_left) retry_cnt <= retry_cnt + RETRY_W'(1);
        end
        ST_NEXT: begin
          entry_idx <= entry_idx + IDX_W'(1);
          retry_cnt <= '0;
        end
        ST_DONE: begin
          entry_idx <= '0;
        end
        ST_FAIL: begin
          error     <= 1'b1;
          err_index <= rom_addr;
          entry_idx <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb_sccb_config_sequencer
//   Directed bench: a behavioural ROM and I2C master surround the sequencer;
//   each scenario loads a small table, runs it and compares counts, timing
//   and status against hand-computed values.
module tb_sccb_config_sequencer;
  import sccb_pkg::*;

  localparam int ADDR_W = 2;
  localparam int LAT    = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [ADDR_W-1:0] rom_addr;
  logic [17:0] rom_entry;
  logic        i2c_start, i2c_read;
  logic [7:0]  i2c_dev_id, i2c_reg, i2c_wdata;
  logic        i2c_done, i2c_ack_ok;
  logic [7:0]  i2c_rdata;
  logic        busy, done, error;
  logic [ADDR_W-1:0] err_index;

  sccb_config_sequencer #(
    .DEVICE_ID(8'h42), .NUM_ENTRIES(4), .ADDR_W(ADDR_W),
    .DELAY_UNIT(10), .MAX_RETRIES(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_entry(rom_entry),
    .i2c_start(i2c_start), .i2c_read(i2c_read), .i2c_dev_id(i2c_dev_id),
    .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata),
    .i2c_done(i2c_done), .i2c_ack_ok(i2c_ack_ok), .i2c_rdata(i2c_rdata),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM model
  logic [17:0] rom [0:3];
  always @(posedge clk) rom_entry <= rom[rom_addr];

  int checks = 0;
  int failures = 0;

  int wr_cnt, rd_cnt, track_cnt, devid_bad, done_cnt, accept_cyc;
  logic [7:0] track_reg, nack_reg, rd_value;
  int nack_left;
  int start_cyc[$];
  logic [15:0] wr_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [17:0] mk(input logic [1:0] op, input logic [7:0] r, input logic [7:0] v);
    return {op, r, v};
  endfunction

  // I2C master model: answers each command LAT cycles after seeing it
  initial begin
    i2c_done = 1'b0; i2c_ack_ok = 1'b0; i2c_rdata = 8'd0;
    forever begin
      @(negedge clk);
      while (i2c_start && reset) begin
        bit aborted;
        bit ack;
        bit is_rd;
        aborted = 1'b0;
        ack = 1'b1;
        is_rd = i2c_read;
        start_cyc.push_back(cyc);
        if (i2c_dev_id !== 8'h42) devid_bad++;
        if (is_rd) rd_cnt++;
        else begin
          wr_cnt++;
          wr_log.push_back({i2c_reg, i2c_wdata});
          if (i2c_reg == track_reg) track_cnt++;
          if (i2c_reg == nack_reg && nack_left > 0) begin
            ack = 1'b0;
            nack_left--;
          end
        end
        for (int i = 0; i < LAT; i++) begin
          @(negedge clk);
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
        end
        if (aborted) break;
        i2c_done = 1'b1;
        i2c_ack_ok = ack;
        i2c_rdata = is_rd ? rd_value : 8'd0;
        @(negedge clk);
        i2c_done = 1'b0; i2c_ack_ok = 1'b0; i2c_rdata = 8'd0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clearCounts();
    wr_cnt = 0; rd_cnt = 0; track_cnt = 0; devid_bad = 0; done_cnt = 0;
    start_cyc.delete(); wr_log.delete();
    track_reg = 8'hFF; nack_reg = 8'hFF; nack_left = 0; rd_value = 8'd0;
  endtask

  task automatic loadRom(input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2, input logic [17:0] e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  // Pulse start, then run until busy drops; optionally re-pulse start mid-run
  task automatic applyStimulus(input string tag, input int glitch_at);
    int t;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    accept_cyc = cyc;
    checkOutput({tag, "_busy_rise"}, busy, 1'b1);
    checkOutput({tag, "_err_clr"}, error, 1'b0);
    t = 0;
    while (busy && t < 2000) begin
      start = (glitch_at != 0 && t == glitch_at);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    checkOutput({tag, "_finished"}, busy, 1'b0);
  endtask

  function automatic int gap(input int a, input int b);
    if (start_cyc.size() > b) return start_cyc[b] - start_cyc[a];
    return -1;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0;
    clearCounts();
    loadRom(18'd0, 18'd0, 18'd0, 18'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rom_addr", rom_addr, 0);
    checkOutput("rst_i2c_start", i2c_start, 1'b0);
    checkOutput("rst_i2c_reg", i2c_reg, 0);
    checkOutput("rst_error", error, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Three writes then END
    clearCounts();
    loadRom(mk(OP_WRITE, 8'h12, 8'h80), mk(OP_WRITE, 8'h40, 8'hD0), mk(OP_WRITE, 8'h1E, 8'h10), mk(OP_END, 8'h00, 8'h00));
    applyStimulus("w3", 0);
    checkOutput("w3_writes", wr_cnt, 3);
    checkOutput("w3_reads", rd_cnt, 0);
    checkOutput("w3_devid", devid_bad, 0);
    checkOutput("w3_done", done_cnt, 1);
    checkOutput("w3_error", error, 1'b0);
    checkOutput("w3_first_start", (start_cyc.size() > 0) ? start_cyc[0] - accept_cyc : -1, 2);
    checkOutput("w3_spacing", gap(0, 1), LAT + 4);
    checkOutput("w3_cmd0", (wr_log.size() > 0) ? wr_log[0] : 16'h0, 16'h1280);
    checkOutput("w3_cmd1", (wr_log.size() > 1) ? wr_log[1] : 16'h0, 16'h40D0);
    checkOutput("w3_cmd2", (wr_log.size() > 2) ? wr_log[2] : 16'h0, 16'h1E10);

    // Full table, termination by count
    clearCounts();
    loadRom(mk(OP_WRITE, 8'h12, 8'h80), mk(OP_WRITE, 8'h40, 8'hD0), mk(OP_WRITE, 8'h1E, 8'h10), mk(OP_WRITE, 8'h55, 8'hAA));
    applyStimulus("cnt", 0);
    checkOutput("cnt_writes", wr_cnt, 4);
    checkOutput("cnt_done", done_cnt, 1);
    checkOutput("cnt_rom_addr", rom_addr, 0);

    // Write-verify, readback matches
    clearCounts();
    rd_value = 8'h04;
    loadRom(mk(OP_VERIFY, 8'h12, 8'h04), mk(OP_END, 8'h00, 8'h00), 18'd0, 18'd0);
    applyStimulus("vok", 0);
    checkOutput("vok_writes", wr_cnt, 1);
    checkOutput("vok_reads", rd_cnt, 1);
    checkOutput("vok_read_gap", gap(0, 1), LAT + 1);
    checkOutput("vok_done", done_cnt, 1);
    checkOutput("vok_error", error, 1'b0);

    // Write-verify, readback always wrong
    clearCounts();
    rd_value = 8'h05;
    applyStimulus("vbad", 0);
    checkOutput("vbad_writes", wr_cnt, 4);
    checkOutput("vbad_reads", rd_cnt, 4);
    checkOutput("vbad_done", done_cnt, 0);
    checkOutput("vbad_error", error, 1'b1);
    checkOutput("vbad_err_index", err_index, 0);

    // NACK on entry 2 twice, then ACK
    clearCounts();
    nack_reg = 8'h1E; nack_left = 2; track_reg = 8'h1E;
    loadRom(mk(OP_WRITE, 8'h12, 8'h80), mk(OP_WRITE, 8'h40, 8'hD0), mk(OP_WRITE, 8'h1E, 8'h10), mk(OP_END, 8'h00, 8'h00));
    applyStimulus("nack2", 0);
    checkOutput("nack2_entry2", track_cnt, 3);
    checkOutput("nack2_writes", wr_cnt, 5);
    checkOutput("nack2_done", done_cnt, 1);
    checkOutput("nack2_error", error, 1'b0);

    // Delay of 3 ticks x 10 cycles between two writes
    clearCounts();
    loadRom(mk(OP_WRITE, 8'h12, 8'h80), mk(OP_DELAY, 8'h00, 8'h03), mk(OP_WRITE, 8'h40, 8'hD0), mk(OP_END, 8'h00, 8'h00));
    applyStimulus("dly3", 0);
    checkOutput("dly3_writes", wr_cnt, 2);
    checkOutput("dly3_spacing", gap(0, 1), LAT + 37);
    checkOutput("dly3_done", done_cnt, 1);

    // Zero-length delay
    clearCounts();
    loadRom(mk(OP_WRITE, 8'h12, 8'h80), mk(OP_DELAY, 8'h00, 8'h00), mk(OP_WRITE, 8'h40, 8'hD0), mk(OP_END, 8'h00, 8'h00));
    applyStimulus("dly0", 0);
    checkOutput("dly0_spacing", gap(0, 1), LAT + 7);

    // END at index 1, extra start while busy
    clearCounts();
    loadRom(mk(OP_WRITE, 8'h12, 8'h80), mk(OP_END, 8'h00, 8'h00), mk(OP_WRITE, 8'h40, 8'hD0), mk(OP_WRITE, 8'h1E, 8'h10));
    applyStimulus("end1", 5);
    repeat (5) @(negedge clk);
    checkOutput("end1_writes", wr_cnt, 1);
    checkOutput("end1_done", done_cnt, 1);
    checkOutput("end1_busy", busy, 1'b0);

    // Persistent NACK on entry 2
    clearCounts();
    nack_reg = 8'h1E; nack_left = 100; track_reg = 8'h1E;
    loadRom(mk(OP_WRITE, 8'h12, 8'h80), mk(OP_WRITE, 8'h40, 8'hD0), mk(OP_WRITE, 8'h1E, 8'h10), mk(OP_END, 8'h00, 8'h00));
    applyStimulus("nackall", 0);
    checkOutput("nackall_entry2", track_cnt, 4);
    checkOutput("nackall_error", error, 1'b1);
    checkOutput("nackall_err_index", err_index, 2);
    checkOutput("nackall_done", done_cnt, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_clears_error", error, 1'b0);
    checkOutput("rst_clears_err_index", err_index, 0);
    reset = 1'b1;

    // Reset while waiting on the master, then rerun from entry 0
    clearCounts();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 50 && wr_cnt == 0; t++) @(negedge clk);
    checkOutput("mid_write_seen", wr_cnt, 1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy", busy, 1'b0);
    checkOutput("mid_i2c_start", i2c_start, 1'b0);
    checkOutput("mid_rom_addr", rom_addr, 0);
    checkOutput("mid_i2c_reg", i2c_reg, 0);
    checkOutput("mid_i2c_wdata", i2c_wdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clearCounts();
    applyStimulus("rerun", 0);
    checkOutput("rerun_cmd0", (wr_log.size() > 0) ? wr_log[0] : 16'h0, 16'h1280);
    checkOutput("rerun_writes", wr_cnt, 3);
    checkOutput("rerun_done", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
